// File: rtl/parity_arb.sv
// parity_arb -- four-requester arbiter that computes the odd parity of the
// granted requester's data nibble.
//
// A winner is chosen from req while idle. The winner is granted for one
// cycle, and its nibble is captured during that grant cycle. The XOR of the
// nibble is then presented on parity_o with a one-cycle valid_o strobe.
// A service takes four cycles from the sampling edge to the next sampling
// edge.
//
// Parameters
//   FAIR       1: round-robin with a rotating pointer
//              0: fixed priority, req[0] highest
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   req[3:0]   request per requester
//   data_i     requester i drives its nibble on data_i[4i+3:4i]
//   gnt[3:0]   registered one-hot grant, high for one cycle per service
//   valid_o    registered result strobe, high for one cycle
//   parity_o   XOR of the granted nibble; held until the next result
//   id_o       index of the requester that parity_o belongs to
//   busy       high whenever the FSM is not idle
//
// Optional build macro PARITY_ERRCNT_EN adds these ports:
//   exp_i[3:0]      expected parity for each requester
//   err_cnt_o[7:0]  saturating count of results that differ from exp_i[id]

module parity_arb #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] data_i,
`ifdef PARITY_ERRCNT_EN
  input  logic [3:0]  exp_i,
  output logic [7:0]  err_cnt_o,
`endif
  output logic [3:0]  gnt,
  output logic        valid_o,
  output logic        parity_o,
  output logic [1:0]  id_o,
  output logic        busy
);

  // state | meaning
  // ------+-----------------------------------------------------------
  // IDLE  | sample req; on any request, latch winner and raise gnt
  // SEL   | gnt high; capture the winner's nibble at the end of cycle
  // CALC  | load parity_o/id_o and raise valid_o at the end of cycle
  // DONE  | valid_o high; return to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] nib_q, nib_d;
  logic [3:0] gnt_d;
  logic       valid_d;
  logic       parity_d;
  logic [1:0] id_d;
  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       found;
`ifdef PARITY_ERRCNT_EN
  logic [7:0] err_d;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    nib_d    = nib_q;
    gnt_d    = '0;
    valid_d  = 1'b0;
    parity_d = parity_o;
    id_d     = id_o;
`ifdef PARITY_ERRCNT_EN
    err_d    = err_cnt_o;
`endif

    // Scan the four requesters starting at base. The 2-bit add wraps 3->0.
    // Fixed priority is the same scan with base pinned to 0.
    base  = (FAIR != 0) ? ptr_q : 2'd0;
    pick  = base;
    cand  = base;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEL;
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
        end
      end
      SEL: begin
        state_d = CALC;
        nib_d   = data_i[{win_q, 2'b00} +: 4];
        if (FAIR != 0) begin
          ptr_d = win_q + 2'd1;
        end
      end
      CALC: begin
        state_d  = DONE;
        valid_d  = 1'b1;
        parity_d = ^nib_q;
        id_d     = win_q;
`ifdef PARITY_ERRCNT_EN
        if (((^nib_q) != exp_i[win_q]) && (err_cnt_o != 8'hFF)) begin
          err_d = err_cnt_o + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset in the middle of a service drops the transaction: the valid_o
  // strobe for it never appears, and the pointer goes back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      ptr_q     <= '0;
      nib_q     <= '0;
      gnt       <= '0;
      valid_o   <= 1'b0;
      parity_o  <= 1'b0;
      id_o      <= '0;
`ifdef PARITY_ERRCNT_EN
      err_cnt_o <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      nib_q     <= nib_d;
      gnt       <= gnt_d;
      valid_o   <= valid_d;
      parity_o  <= parity_d;
      id_o      <= id_d;
`ifdef PARITY_ERRCNT_EN
      err_cnt_o <= err_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parity_arb.sv
// Testbench for parity_arb. A round-robin instance and a fixed-priority
// instance receive the same stimulus. Each service pushes its expected grant
// and result into queues. A monitor running on the falling edge compares
// every cycle against those queues.

module tb_parity_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data_i;
  logic [3:0]  exp_v;

  logic [3:0]  gnt_rr, gnt_fp;
  logic        valid_rr, valid_fp;
  logic        par_rr, par_fp;
  logic [1:0]  id_rr, id_fp;
  logic        busy_rr, busy_fp;
`ifdef PARITY_ERRCNT_EN
  logic [7:0]  err_rr, err_fp;
`endif

  always #5 clk = ~clk;

  parity_arb #(.FAIR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .data_i(data_i),
`ifdef PARITY_ERRCNT_EN
    .exp_i(exp_v), .err_cnt_o(err_rr),
`endif
    .gnt(gnt_rr), .valid_o(valid_rr), .parity_o(par_rr), .id_o(id_rr),
    .busy(busy_rr)
  );

  parity_arb #(.FAIR(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .data_i(data_i),
`ifdef PARITY_ERRCNT_EN
    .exp_i(exp_v), .err_cnt_o(err_fp),
`endif
    .gnt(gnt_fp), .valid_o(valid_fp), .parity_o(par_fp), .id_o(id_fp),
    .busy(busy_fp)
  );

  typedef struct {
    int         cyc;
    logic [3:0] g_rr, g_fp;
    logic       p_rr, p_fp;
    logic [1:0] i_rr, i_fp;
    int         e_rr, e_fp;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int ptr_m = 0;
  int s_last = -100;
  int err_m_rr = 0;
  int err_m_fp = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic par(input logic [3:0] n);
    return ($countones(n) % 2) == 1;
  endfunction

  always @(negedge clk) begin : mon
    logic [3:0] eg_rr, eg_fp;
    logic       ev, eb;
    exp_t       e;
    if (mon_on) begin
      eg_rr = '0;
      eg_fp = '0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        eg_rr = gq[0].g_rr;
        eg_fp = gq[0].g_fp;
        void'(gq.pop_front());
      end
      check("gnt_rr", gnt_rr, eg_rr);
      check("gnt_fp", gnt_fp, eg_fp);
      ev = (rq.size() > 0 && rq[0].cyc + 2 == cyc);
      check("valid_rr", valid_rr, ev);
      check("valid_fp", valid_fp, ev);
      if (ev) begin
        e = rq.pop_front();
        check("parity_rr", par_rr, e.p_rr);
        check("parity_fp", par_fp, e.p_fp);
        check("id_rr", id_rr, e.i_rr);
        check("id_fp", id_fp, e.i_fp);
`ifdef PARITY_ERRCNT_EN
        check("errcnt_rr", err_rr, e.e_rr);
        check("errcnt_fp", err_fp, e.e_fp);
`endif
      end
      eb = (cyc >= s_last && cyc <= s_last + 2);
      check("busy_rr", busy_rr, eb);
      check("busy_fp", busy_fp, eb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_gnt_rr"}, gnt_rr, 4'd0);
    check({nm, "_gnt_fp"}, gnt_fp, 4'd0);
    check({nm, "_valid"}, {valid_rr, valid_fp}, 2'd0);
    check({nm, "_parity"}, {par_rr, par_fp}, 2'd0);
    check({nm, "_id"}, {id_rr, id_fp}, 4'd0);
    check({nm, "_busy"}, {busy_rr, busy_fp}, 2'd0);
`ifdef PARITY_ERRCNT_EN
    check({nm, "_errcnt"}, {err_rr, err_fp}, 16'd0);
`endif
  endtask

  task automatic model_reset();
    ptr_m    = 0;
    s_last   = -100;
    err_m_rr = 0;
    err_m_fp = 0;
  endtask

  // One service slot: drive req/data, then disturb the inputs while the DUT
  // is busy and must ignore them. emode 0 = random exp, 1 = exp wrong for
  // every requester, 2 = exp correct. If do_rst is set, the service is
  // aborted by a reset during CALC.
  task automatic service(input logic [3:0] r, input logic [15:0] d,
                         input int emode, input bit do_rst);
    exp_t       e;
    int         wr, wf;
    logic [3:0] pv;
    tick();
    req    = r;
    data_i = d;
    for (int k = 0; k < 4; k++) pv[k] = par(d[4*k +: 4]);
    case (emode)
      0:       exp_v = 4'($urandom);
      1:       exp_v = ~pv;
      default: exp_v = pv;
    endcase
    if (r == 4'd0) return;
    wr    = pick(r, ptr_m);
    wf    = pick(r, 0);
    ptr_m = (wr + 1) % 4;
    if (pv[wr] != exp_v[wr] && err_m_rr < 255) err_m_rr++;
    if (pv[wf] != exp_v[wf] && err_m_fp < 255) err_m_fp++;
    e.cyc  = cyc + 1;
    e.g_rr = 4'b0001 << wr;
    e.g_fp = 4'b0001 << wf;
    e.p_rr = pv[wr];
    e.p_fp = pv[wf];
    e.i_rr = 2'(wr);
    e.i_fp = 2'(wf);
    e.e_rr = err_m_rr;
    e.e_fp = err_m_fp;
    s_last = e.cyc;
    gq.push_back(e);
    if (!do_rst) rq.push_back(e);
    tick();
    tick();
    req    = 4'($urandom);
    data_i = 16'($urandom);
    if (do_rst) begin
      rst = 1'b1;
      tick();
      model_reset();
      check_zero("mid_rst");
      rst = 1'b0;
      req = 4'd0;
      return;
    end
    tick();
    req    = 4'($urandom);
    data_i = 16'($urandom);
    exp_v  = 4'($urandom);
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    req = 4'd0;
    tick();
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'd0;
    data_i = 16'd0;
    exp_v  = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    mon_on = 1'b1;
    rst    = 1'b0;

    // Single request from requester 0 with nibble 1011: expected parity 1.
    service(4'b0001, {12'($urandom), 4'b1011}, 0, 1'b0);

    // Abort during CALC. The next round-robin grant must start from 0.
    service(4'b1111, 16'($urandom), 0, 1'b1);

    // All four requesting, five services in a row.
    for (int i = 0; i < 5; i++) service(4'b1111, 16'($urandom), 0, 1'b0);

    // Requesters 1 and 3: fixed priority always picks 1.
    for (int i = 0; i < 6; i++) service(4'b1010, 16'($urandom), 0, 1'b0);

    // Sweep all 16 nibble values on requester 2.
    for (int v = 0; v < 16; v++) begin
      logic [15:0] d;
      d = 16'($urandom);
      d[11:8] = 4'(v);
      service(4'b0100, d, 0, 1'b0);
    end

    // Random traffic with gaps and occasional aborts.
    for (int i = 0; i < 60; i++) begin
      service(4'($urandom), 16'($urandom), 0, ($urandom % 10) == 0);
    end

`ifdef PARITY_ERRCNT_EN
    pulse_rst();
    for (int i = 0; i < 260; i++) service(4'($urandom_range(15, 1)), 16'($urandom), 1, 1'b0);
    check("errcnt_sat_rr", err_rr, 8'd255);
    check("errcnt_sat_fp", err_fp, 8'd255);
    pulse_rst();
    for (int i = 0; i < 20; i++) service(4'($urandom_range(15, 1)), 16'($urandom), 2, 1'b0);
    check("errcnt_clean_rr", err_rr, 8'd0);
    check("errcnt_clean_fp", err_fp, 8'd0);
`endif

    tick();
    req = 4'd0;
    repeat (8) tick();
    check("grant_queue_drained", gq.size(), 0);
    check("result_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
